e_mdu_param: RTL

//  Parametrised multi-cycle multiply/divide unit (HI/LO) for the E stage of the pipelined CPU.
//  - Accepts one op per start pulse and holds busy for a fixed, per-op-class latency.
//  - Commits results to HI/LO only when the op completes; D-stage stall logic keys off out_busy.
//  - Generalises the fixed 32-bit HILO block: configurable width and latencies, a done pulse,

---
 rtl/e_mdu_param.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/e_mdu_param.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO for the E stage.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_ACCUMULATE_EN.
module e_mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_start,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_num1,
    input  logic [WIDTH-1:0] in_num2,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             out_busy,
    output logic             out_done
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int W2         = 2 * WIDTH;

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic [WIDTH-1:0]  pend_hi_q, pend_lo_q;
    logic              pend_wr_q;
    logic              done_q;

    logic              accept;
    logic              commit;
    logic              is_multi;
    logic [CNT_W-1:0]  n_cycles;
    logic [WIDTH-1:0]  res_hi, res_lo;
    logic              res_wr;

    // ---------------- datapath ----------------
    logic [W2-1:0]            a_sext, b_sext, a_zext, b_zext;
    logic [W2-1:0]            prod_s, prod_u;
    logic                     div_zero, div_ovf;
    logic [WIDTH-1:0]         div_u;
    logic signed [WIDTH-1:0]  div_s;
    logic signed [WIDTH-1:0]  quo_s, rem_s;
    logic [WIDTH-1:0]         quo_u, rem_u;

    assign a_sext = {{WIDTH{in_num1[WIDTH-1]}}, in_num1};
    assign b_sext = {{WIDTH{in_num2[WIDTH-1]}}, in_num2};
    assign a_zext = {{WIDTH{1'b0}}, in_num1};
    assign b_zext = {{WIDTH{1'b0}}, in_num2};

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign prod_s = a_sext * b_sext;
    assign prod_u = a_zext * b_zext;

    // Substituting a divisor of 1 keeps the dividers defined for x/0 and makes
    // INT_MIN/-1 yield quotient INT_MIN, remainder 0 without a special path.
    assign div_zero = (in_num2 == '0);
    assign div_ovf  = (in_num1 == INT_MIN) && (in_num2 == '1);
    assign div_u    = div_zero ? ONE : in_num2;
    assign div_s    = (div_zero || div_ovf) ? $signed(ONE) : $signed(in_num2);
    assign quo_s    = $signed(in_num1) / div_s;
    assign rem_s    = $signed(in_num1) % div_s;
    assign quo_u    = in_num1 / div_u;
    assign rem_u    = in_num1 % div_u;

`ifdef MDU_ACCUMULATE_EN
    logic [W2-1:0] hilo;
    assign hilo = {hi_q, lo_q};
`endif

    assign accept = in_start && (state_q == S_IDLE);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        is_multi = 1'b0;
        n_cycles = '0;
        res_hi   = hi_q;
        res_lo   = lo_q;
        res_wr   = 1'b0;
        case (in_op)
            OP_MULT: begin
                is_multi         = 1'b1;
                n_cycles         = MULT_N;
                {res_hi, res_lo} = prod_s;
                res_wr           = 1'b1;
            end
            OP_MULTU: begin
                is_multi         = 1'b1;
                n_cycles         = MULT_N;
                {res_hi, res_lo} = prod_u;
                res_wr           = 1'b1;
            end
            OP_DIV: begin
                is_multi = 1'b1;
                n_cycles = DIV_N;
                res_lo   = quo_s;
                res_hi   = rem_s;
                res_wr   = !div_zero;
            end
            OP_DIVU: begin
                is_multi = 1'b1;
                n_cycles = DIV_N;
                res_lo   = quo_u;
                res_hi   = rem_u;
                res_wr   = !div_zero;
            end
`ifdef MDU_ACCUMULATE_EN
            OP_MADD: begin
                is_multi         = 1'b1;
                n_cycles         = MULT_N;
                {res_hi, res_lo} = hilo + prod_s;
                res_wr           = 1'b1;
            end
            OP_MADDU: begin
                is_multi         = 1'b1;
                n_cycles         = MULT_N;
                {res_hi, res_lo} = hilo + prod_u;
                res_wr           = 1'b1;
            end
            OP_MSUB: begin
                is_multi         = 1'b1;
                n_cycles         = MULT_N;
                {res_hi, res_lo} = hilo - prod_s;
                res_wr           = 1'b1;
            end
            OP_MSUBU: begin
                is_multi         = 1'b1;
                n_cycles         = MULT_N;
                {res_hi, res_lo} = hilo - prod_u;
                res_wr           = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_multi) begin
                    state_d = S_BUSY;
                    cnt_d   = n_cycles;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == ONE[CNT_W-1:0]) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= commit;
            if (accept && is_multi) begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_wr_q <= res_wr;
            end
            if (commit && pend_wr_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end else if (accept && in_op == OP_MTHI) begin
                hi_q <= in_num1;
            end else if (accept && in_op == OP_MTLO) begin
                lo_q <= in_num1;
            end
        end
    end

    assign out_hi   = hi_q;
    assign out_lo   = lo_q;
    assign out_busy = (state_q == S_BUSY);
    assign out_done = done_q;

endmodule
